// File: rtl/dmem_unit_pkg.sv
// ---------------------------------------------------------------------------
// dmem_unit_pkg
// Shared types and helpers for the data-memory stage and the LSQ.
//   sb_entry_t    : one retired store held in the commit buffer
//   ld_state_e    : load-path FSM states
//   OPC_* / F3_*  : opcode and func3 encodings used by the memory pipeline
//   rob_in_range  : circular exclusive range test used for squash decisions
// ---------------------------------------------------------------------------
package dmem_unit_pkg;

  localparam int ROB_SIZE  = 16;
  localparam int ROB_TAG_W = 5;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [2:0] F3_LW    = 3'b010;
  localparam logic [2:0] F3_LBU   = 3'b100;
  localparam logic [2:0] F3_SW    = 3'b010;
  localparam logic [2:0] F3_SH    = 3'b001;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        half;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_FWD
  } ld_state_e;

  // True when tag lies strictly between lo and hi, walking forward modulo
  // ROB_SIZE. Distances are taken relative to lo so the wrap is free.
  function automatic logic rob_in_range(input logic [ROB_TAG_W-1:0] tag,
                                        input logic [ROB_TAG_W-1:0] lo,
                                        input logic [ROB_TAG_W-1:0] hi);
    logic [ROB_TAG_W-1:0] mask;
    logic [ROB_TAG_W-1:0] dist_tag;
    logic [ROB_TAG_W-1:0] dist_hi;
    mask     = ROB_TAG_W'(ROB_SIZE - 1);
    dist_tag = (tag - lo) & mask;
    dist_hi  = (hi - lo) & mask;
    return (dist_tag != '0) && (dist_tag < dist_hi);
  endfunction

endpackage

// File: rtl/dmem_unit_store_commit_buf.sv
// ---------------------------------------------------------------------------
// dmem_unit_store_commit_buf
// In-order FIFO of retired stores waiting to be written to the data RAM,
// with a parallel word-address compare used for load hazard detection.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   push_i            : enqueue push_entry_i (dropped when full)
//   push_entry_i      : store payload {addr, data, half}
//   pop_i             : dequeue the head entry (ignored when empty)
//   cmp_word_i        : word address (addr[31:2]) to compare against
//   head_o            : oldest buffered entry
//   empty_o, full_o   : occupancy flags
//   match_o           : some valid entry, or the entry being pushed this
//                       cycle, targets cmp_word_i
// ---------------------------------------------------------------------------
module dmem_unit_store_commit_buf
  import dmem_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  sb_entry_t   push_entry_i,
  input  logic        pop_i,
  input  logic [29:0] cmp_word_i,
  output sb_entry_t   head_o,
  output logic        empty_o,
  output logic        full_o,
  output logic        match_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sb_entry_t        entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = entry_q[head_q];

  // Push and pop never target the same slot: that needs head == tail,
  // which only happens when empty (no pop) or full (no push).
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
    if (pop_ok) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (push_ok) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      entry_q[tail_q] <= push_entry_i;
    end
  end

  // An entry being popped this cycle still counts; the load simply waits
  // one more cycle, which keeps the RAM write ahead of the read.
  always_comb begin
    match_o = push_ok && (push_entry_i.addr[31:2] == cmp_word_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i].addr[31:2] == cmp_word_i)) begin
        match_o = 1'b1;
      end
    end
  end

  // The LSQ must hold retirement while the buffer is full.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
                                        !(push_i && full_o));

endmodule

// File: rtl/dmem_unit.sv
// ---------------------------------------------------------------------------
// dmem_unit
// Data-memory stage behind the LSQ. Buffers retired stores and drains them
// into a single-port RAM, services loads by forwarding or RAM read, and
// returns load results as a one-cycle writeback pulse.
// Ports:
//   clk, reset                       : clock, asynchronous active-low reset
//   store_wb, st_addr/data/half      : retired store (half=1 sh, 0 sw)
//   sb_full                          : commit buffer full, hold retirement
//   ld_req, ld_addr, ld_func3,
//   ld_pd, ld_rob_tag                : issued load
//   ld_fwd_valid, ld_fwd_data        : LSQ forwarded data for that load
//   ld_busy                          : load path occupied, ld_req ignored
//   mispredict, mispredict_tag,
//   curr_rob_tag                     : squash strobe and tag window
//   wb_valid, wb_data, wb_pd,
//   wb_rob_tag                       : load writeback pulse
// ---------------------------------------------------------------------------
module dmem_unit
  import dmem_unit_pkg::*;
#(
  parameter int SB_DEPTH  = 4,
  parameter int MEM_WORDS = 1024,
  parameter int PD_W      = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 store_wb,
  input  logic [31:0]          st_addr,
  input  logic [31:0]          st_data,
  input  logic                 st_half,
  output logic                 sb_full,
  input  logic                 ld_req,
  input  logic                 ld_fwd_valid,
  input  logic [31:0]          ld_fwd_data,
  input  logic [31:0]          ld_addr,
  input  logic [2:0]           ld_func3,
  input  logic [PD_W-1:0]      ld_pd,
  input  logic [ROB_TAG_W-1:0] ld_rob_tag,
  output logic                 ld_busy,
  input  logic                 mispredict,
  input  logic [ROB_TAG_W-1:0] mispredict_tag,
  input  logic [ROB_TAG_W-1:0] curr_rob_tag,
  output logic                 wb_valid,
  output logic [31:0]          wb_data,
  output logic [PD_W-1:0]      wb_pd,
  output logic [ROB_TAG_W-1:0] wb_rob_tag
);

  localparam int AW = $clog2(MEM_WORDS);

  ld_state_e            state_q, state_d;
  logic [PD_W-1:0]      ld_pd_q;
  logic [ROB_TAG_W-1:0] ld_tag_q;
  logic [31:0]          ld_addr_q;
  logic [2:0]           ld_f3_q;
  logic [31:0]          fwd_data_q;
  logic                 rd_pend_q;
  logic [31:0]          rd_data_q;
  logic                 wb_valid_q, wb_valid_d;
  logic [31:0]          wb_data_q, wb_data_d;
  logic [PD_W-1:0]      wb_pd_q;
  logic [ROB_TAG_W-1:0] wb_tag_q;

  logic [31:0]          mem [MEM_WORDS];

  sb_entry_t            sb_push_entry;
  sb_entry_t            sb_head;
  logic                 sb_empty;
  logic                 sb_match;
  logic [29:0]          cmp_word;

  logic                 squash_held;
  logic                 squash_new;
  logic                 accept;
  logic                 read_go;
  logic                 drain;
  logic                 wb_fwd;
  logic                 wb_rd;
  logic [7:0]           rd_byte;
  logic [31:0]          rd_result;
  logic [AW-1:0]        wr_idx;
  logic [31:0]          wr_data;
  logic [3:0]           wr_be;
  logic                 unused_head_bits;

  assign sb_push_entry = '{addr: st_addr, data: st_data, half: st_half};

  // In IDLE the incoming load is checked; afterwards the held one.
  assign cmp_word = (state_q == ST_IDLE) ? ld_addr[31:2] : ld_addr_q[31:2];

  dmem_unit_store_commit_buf #(
    .DEPTH(SB_DEPTH)
  ) u_scb (
    .clk          (clk),
    .reset        (reset),
    .push_i       (store_wb),
    .push_entry_i (sb_push_entry),
    .pop_i        (drain),
    .cmp_word_i   (cmp_word),
    .head_o       (sb_head),
    .empty_o      (sb_empty),
    .full_o       (sb_full),
    .match_o      (sb_match)
  );

  // ld_tag_q covers both the load held in WAIT/READ/FWD and the read that
  // is completing, since a new load is only captured on the same edge.
  assign squash_held = mispredict && rob_in_range(ld_tag_q, mispredict_tag, curr_rob_tag);
  assign squash_new  = mispredict && rob_in_range(ld_rob_tag, mispredict_tag, curr_rob_tag);
  assign accept      = ld_req && (state_q == ST_IDLE) && !squash_new;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (ld_fwd_valid)  state_d = ST_FWD;
          else if (sb_match) state_d = ST_WAIT;
          else               state_d = ST_READ;
        end
      end
      ST_WAIT: begin
        if (squash_held)    state_d = ST_IDLE;
        else if (!sb_match) state_d = ST_READ;
      end
      ST_READ: begin
        if (squash_held || read_go) state_d = ST_IDLE;
      end
      ST_FWD: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A full buffer takes the RAM port even from a pending READ.
  always_comb begin
    ld_busy = (state_q != ST_IDLE);
    read_go = (state_q == ST_READ) && !sb_full && !squash_held;
    drain   = !sb_empty && !read_go;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_pd_q    <= '0;
      ld_tag_q   <= '0;
      ld_addr_q  <= '0;
      ld_f3_q    <= '0;
      fwd_data_q <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      rd_pend_q <= read_go;
      if (accept) begin
        ld_pd_q    <= ld_pd;
        ld_tag_q   <= ld_rob_tag;
        ld_addr_q  <= ld_addr;
        ld_f3_q    <= ld_func3;
        fwd_data_q <= ld_fwd_data;
      end
    end
  end

  // sh replicates the halfword into both halves and enables only the
  // two lanes selected by addr[1]; sw writes the whole word.
  always_comb begin
    wr_idx = sb_head.addr[AW+1:2];
    if (sb_head.half) begin
      wr_data = {sb_head.data[15:0], sb_head.data[15:0]};
      wr_be   = sb_head.addr[1] ? 4'b1100 : 4'b0011;
    end else begin
      wr_data = sb_head.data;
      wr_be   = 4'b1111;
    end
  end

  assign unused_head_bits = ^{sb_head.addr[31:AW+2], sb_head.addr[0]};

  always_ff @(posedge clk) begin
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
    if (read_go) begin
      rd_data_q <= mem[ld_addr_q[AW+1:2]];
    end
  end

  // FWD and a completing read cannot coincide: FWD is entered only from
  // IDLE, which never issues a read.
  always_comb begin
    rd_byte    = rd_data_q[{ld_addr_q[1:0], 3'b000} +: 8];
    rd_result  = (ld_f3_q == F3_LBU) ? {24'b0, rd_byte} : rd_data_q;
    wb_fwd     = (state_q == ST_FWD) && !squash_held;
    wb_rd      = rd_pend_q && !squash_held;
    wb_valid_d = wb_fwd || wb_rd;
    wb_data_d  = wb_fwd ? fwd_data_q : rd_result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_pd_q    <= '0;
      wb_tag_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      if (wb_valid_d) begin
        wb_data_q <= wb_data_d;
        wb_pd_q   <= ld_pd_q;
        wb_tag_q  <= ld_tag_q;
      end
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_pd      = wb_pd_q;
  assign wb_rob_tag = wb_tag_q;

endmodule

// File: tb/tb_dmem_unit.sv
// ---------------------------------------------------------------------------
// tb_dmem_unit
// Directed testbench for dmem_unit: store buffering and drain, forwarded,
// clean and hazard loads, buffer-full behaviour, squash and async reset.
// ---------------------------------------------------------------------------
module tb_dmem_unit;

  localparam int PD_W = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic            store_wb;
  logic [31:0]     st_addr;
  logic [31:0]     st_data;
  logic            st_half;
  logic            sb_full;
  logic            ld_req;
  logic            ld_fwd_valid;
  logic [31:0]     ld_fwd_data;
  logic [31:0]     ld_addr;
  logic [2:0]      ld_func3;
  logic [PD_W-1:0] ld_pd;
  logic [4:0]      ld_rob_tag;
  logic            ld_busy;
  logic            mispredict;
  logic [4:0]      mispredict_tag;
  logic [4:0]      curr_rob_tag;
  logic            wb_valid;
  logic [31:0]     wb_data;
  logic [PD_W-1:0] wb_pd;
  logic [4:0]      wb_rob_tag;

  int checks = 0;
  int passes = 0;
  int cyc;

  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;

  always #5 clk = ~clk;

  dmem_unit #(
    .SB_DEPTH  (4),
    .MEM_WORDS (1024),
    .PD_W      (PD_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .store_wb       (store_wb),
    .st_addr        (st_addr),
    .st_data        (st_data),
    .st_half        (st_half),
    .sb_full        (sb_full),
    .ld_req         (ld_req),
    .ld_fwd_valid   (ld_fwd_valid),
    .ld_fwd_data    (ld_fwd_data),
    .ld_addr        (ld_addr),
    .ld_func3       (ld_func3),
    .ld_pd          (ld_pd),
    .ld_rob_tag     (ld_rob_tag),
    .ld_busy        (ld_busy),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .curr_rob_tag   (curr_rob_tag),
    .wb_valid       (wb_valid),
    .wb_data        (wb_data),
    .wb_pd          (wb_pd),
    .wb_rob_tag     (wb_rob_tag)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
  endtask

  task automatic clearInputs();
    store_wb     = 1'b0;
    st_addr      = '0;
    st_data      = '0;
    st_half      = 1'b0;
    ld_req       = 1'b0;
    ld_fwd_valid = 1'b0;
    ld_fwd_data  = '0;
    ld_addr      = '0;
    ld_func3     = '0;
    ld_pd        = '0;
    ld_rob_tag   = '0;
    mispredict   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of store/load/squash inputs, then returns #1 after
  // the edge that sampled them with all strobes cleared again.
  task automatic applyStimulus(input logic sv, input logic [31:0] sa,
                               input logic [31:0] sd, input logic sh,
                               input logic lv, input logic fv,
                               input logic [31:0] fd, input logic [31:0] la,
                               input logic [2:0] f3, input logic [PD_W-1:0] pd,
                               input logic [4:0] tag, input logic mp);
    store_wb     = sv;
    st_addr      = sa;
    st_data      = sd;
    st_half      = sh;
    ld_req       = lv;
    ld_fwd_valid = fv;
    ld_fwd_data  = fd;
    ld_addr      = la;
    ld_func3     = f3;
    ld_pd        = pd;
    ld_rob_tag   = tag;
    mispredict   = mp;
    tick();
    clearInputs();
  endtask

  // Cycles until wb_valid is seen, or -1 when the budget runs out.
  task automatic waitWb(input int limit, output int cycles);
    cycles = -1;
    for (int n = 1; n <= limit; n++) begin
      tick();
      if (wb_valid) begin
        cycles = n;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearInputs();
    mispredict_tag = 5'd4;
    curr_rob_tag   = 5'd9;
    reset          = 1'b0;
    #12;
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_wb_pd", 32'(wb_pd), 32'd0);
    checkOutput("rst_wb_tag", 32'(wb_rob_tag), 32'd0);
    checkOutput("rst_sb_full", 32'(sb_full), 32'd0);
    checkOutput("rst_ld_busy", 32'(ld_busy), 32'd0);
    reset = 1'b1;
    tick();

    // sw then clean lw of the same word after it drains
    applyStimulus(1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h100, LW, 7'd5, 5'd1, 0);
    checkOutput("lw_busy", 32'(ld_busy), 32'd1);
    waitWb(6, cyc);
    checkOutput("lw_latency", cyc, 32'd2);
    checkOutput("lw_data", wb_data, 32'hDEADBEEF);
    checkOutput("lw_pd", 32'(wb_pd), 32'd5);
    checkOutput("lw_tag", 32'(wb_rob_tag), 32'd1);
    tick();
    checkOutput("wb_pulse", 32'(wb_valid), 32'd0);

    // sh pushed in the same cycle as an lbu to that word -> hazard wait
    applyStimulus(1, 32'h102, 32'h0000CAFE, 1, 1, 0, 0, 32'h103, LBU, 7'd6, 5'd2, 0);
    checkOutput("hazard_busy", 32'(ld_busy), 32'd1);
    waitWb(10, cyc);
    checkOutput("hazard_latency", cyc, 32'd4);
    checkOutput("lbu_data", wb_data, 32'h000000CA);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h100, LW, 7'd7, 5'd3, 0);
    waitWb(6, cyc);
    checkOutput("merge_latency", cyc, 32'd2);
    checkOutput("merge_data", wb_data, 32'hCAFEBEEF);

    // forwarded load returns the LSQ data, not the RAM word
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h12345678, 32'h100, LW, 7'd9, 5'd3, 0);
    waitWb(4, cyc);
    checkOutput("fwd_latency", cyc, 32'd1);
    checkOutput("fwd_data", wb_data, 32'h12345678);
    checkOutput("fwd_pd", 32'(wb_pd), 32'd9);
    checkOutput("fwd_tag", 32'(wb_rob_tag), 32'd3);

    // back-to-back stores with loads stealing every other port cycle
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 32'h300 + 32'(4*i), 32'hA0000000 + 32'(i), 0,
                    (i % 2) == 0, 0, 0, 32'h100, LW, 7'd1, 5'd1, 0);
      if (i == 4) checkOutput("count3_not_full", 32'(sb_full), 32'd0);
      if (i == 5) checkOutput("sb_full_set", 32'(sb_full), 32'd1);
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h100, LW, 7'd1, 5'd1, 0);
    checkOutput("sb_full_drained", 32'(sb_full), 32'd0);
    repeat (8) tick();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h300 + 32'(4*i), LW, 7'(i), 5'(i), 0);
      waitWb(6, cyc);
      checkOutput($sformatf("readback%0d", i), wb_data, 32'hA0000000 + 32'(i));
    end

    // squash while in READ: tag 6 lies in (4,9)
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h100, LW, 7'd2, 5'd6, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("squash_idle", 32'(ld_busy), 32'd0);
    waitWb(3, cyc);
    checkOutput("squash_no_wb", cyc, 32'hFFFFFFFF);

    // tag 2 is outside (4,9) and survives the same mispredict
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h100, LW, 7'd2, 5'd2, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    waitWb(3, cyc);
    checkOutput("survive_latency", cyc, 32'd1);
    checkOutput("survive_tag", 32'(wb_rob_tag), 32'd2);
    checkOutput("survive_data", wb_data, 32'hCAFEBEEF);

    // squash lands on the completing read; squashed new load refused
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h100, LW, 7'd2, 5'd6, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h55, 32'h100, LW, 7'd3, 5'd7, 1);
    checkOutput("pend_squash_wb", 32'(wb_valid), 32'd0);
    checkOutput("new_squash_busy", 32'(ld_busy), 32'd0);
    waitWb(3, cyc);
    checkOutput("pend_squash_no_wb", cyc, 32'hFFFFFFFF);

    // build three buffered stores, enter WAIT, then reset asynchronously
    repeat (2) tick();
    applyStimulus(1, 32'h500, 32'hB0, 0, 1, 0, 0, 32'h100, LW, 7'd1, 5'd1, 0);
    applyStimulus(1, 32'h504, 32'hB1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h508, 32'hB2, 0, 1, 0, 0, 32'h100, LW, 7'd1, 5'd1, 0);
    applyStimulus(1, 32'h50C, 32'hB3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h510, 32'hB4, 0, 1, 0, 0, 32'h50C, LW, 7'd3, 5'd8, 0);
    checkOutput("wait_busy", 32'(ld_busy), 32'd1);
    checkOutput("pre_rst_wb", 32'(wb_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("async_wb_data", wb_data, 32'd0);
    checkOutput("async_wb_pd", 32'(wb_pd), 32'd0);
    checkOutput("async_wb_tag", 32'(wb_rob_tag), 32'd0);
    checkOutput("async_ld_busy", 32'(ld_busy), 32'd0);
    checkOutput("async_sb_full", 32'(sb_full), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h50C, LW, 7'd4, 5'd9, 0);
    waitWb(8, cyc);
    checkOutput("post_rst_no_hazard", cyc, 32'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
